// File: rtl/sudoku_stim_checker_pkg.sv
// Purpose: shared types and index helpers for the sudoku solver stimulus/checker.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package sudoku_stim_checker_pkg;

  localparam int CELLS = 81;
  localparam int N     = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_RECV,
    ST_REPORT
  } state_t;

  // Raster index 0..80 to row 0..8.
  function automatic logic [3:0] idx_row(input logic [6:0] idx);
    return 4'(idx / 7'd9);
  endfunction

  // Raster index 0..80 to column 0..8.
  function automatic logic [3:0] idx_col(input logic [6:0] idx);
    return 4'(idx % 7'd9);
  endfunction

  // Raster index 0..80 to 3x3 box 0..8, boxes numbered in raster order.
  function automatic logic [3:0] idx_box(input logic [6:0] idx);
    return 4'((idx / 7'd27) * 7'd3 + (idx % 7'd9) / 7'd3);
  endfunction

endpackage

// File: rtl/sudoku_stim_checker_rcb.sv
// Purpose: row/column/box digit-seen masks; flags a digit already seen in the cell's row, col or box.
// Latency: dup is combinational from the current masks; an update is visible from the next clock.
// Backpressure: none; one (idx, val) update per cycle when upd is high.
// Ports: clk, rst (sync, active-high), clr (sync clear of all masks), upd (record val at idx),
//        idx (raster cell 0..80), val (returned digit), dup (val already present in row/col/box).
module sudoku_rcb_tracker
  import sudoku_stim_checker_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       upd,
  input  logic [6:0] idx,
  input  logic [3:0] val,
  output logic       dup
);

  logic [N-1:0] row_m [N];
  logic [N-1:0] col_m [N];
  logic [N-1:0] box_m [N];

  logic [3:0]   r;
  logic [3:0]   c;
  logic [3:0]   b;
  logic         val_ok;
  logic [N-1:0] bit_oh;

  assign r      = idx_row(idx);
  assign c      = idx_col(idx);
  assign b      = idx_box(idx);
  assign val_ok = (val != 4'd0) && (val <= 4'd9);

  // One-hot digit position; all-zero for out-of-range values so they never mark or match.
  always_comb begin
    bit_oh = '0;
    if (val_ok) bit_oh[val - 4'd1] = 1'b1;
  end

  assign dup = |((row_m[r] | col_m[c] | box_m[b]) & bit_oh);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < N; i++) begin
        row_m[i] <= '0;
        col_m[i] <= '0;
        box_m[i] <= '0;
      end
    end else if (upd) begin
      row_m[r] <= row_m[r] | bit_oh;
      col_m[c] <= col_m[c] | bit_oh;
      box_m[b] <= box_m[b] | bit_oh;
    end
  end

endmodule

// File: rtl/sudoku_stim_checker.sv
// Purpose: loads a puzzle, streams it to a sudoku solver, checks the returned grid and reports a verdict.
// Latency: 81-cycle send burst, solver latency (bounded by TIMEOUT_CYC), 81-cycle receive, done one cycle after REPORT.
// Backpressure: none; the solver must accept the burst and return 81 contiguous valid cells, gaps are protocol errors.
// Ports: clk, rst (sync, active-high); ld_valid/ld_data puzzle load; start launches a run; busy while running;
//        sol_in_valid/sol_in to solver; sol_out_valid/sol_out from solver; done pulse with pass, err_cnt,
//        latency, timeout, proto_err results held until the next accepted start.
module sudoku_stim_checker
  import sudoku_stim_checker_pkg::*;
#(
  parameter int TIMEOUT_CYC = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  input  logic [3:0]  ld_data,
  input  logic        start,
  output logic        busy,
  output logic        sol_in_valid,
  output logic [3:0]  sol_in,
  input  logic        sol_out_valid,
  input  logic [3:0]  sol_out,
  output logic        done,
  output logic        pass,
  output logic [6:0]  err_cnt,
  output logic [11:0] latency,
  output logic        timeout,
  output logic        proto_err
);

  // A limit beyond the counter range trips when the counter saturates.
  localparam logic [11:0] TO_LIM = (TIMEOUT_CYC > 4095) ? 12'd4095 : 12'(TIMEOUT_CYC);
  localparam logic [6:0]  LAST   = 7'(CELLS - 1);
  localparam logic [6:0]  FULL   = 7'(CELLS);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  buffer [CELLS];
  logic [6:0]  ld_ptr;
  logic [6:0]  send_idx;
  logic [6:0]  recv_idx;
  logic [6:0]  cell_idx;
  logic        cell_en;
  logic        cell_err;
  logic        dup;
  logic        start_ok;
  logic [3:0]  given;
  logic [11:0] lat_nxt;
  logic        lat_hit;

  assign lat_nxt = (latency == 12'hFFF) ? latency : latency + 12'd1;
  assign lat_hit = (lat_nxt >= TO_LIM);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    start_ok     = 1'b0;
    busy         = (state != ST_IDLE);
    sol_in_valid = 1'b0;
    sol_in       = 4'd0;
    cell_en      = 1'b0;
    cell_idx     = 7'd0;
    case (state)
      ST_IDLE: begin
        if (start && (ld_ptr == FULL)) begin
          start_ok  = 1'b1;
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        sol_in_valid = 1'b1;
        sol_in       = buffer[send_idx];
        if (send_idx == LAST) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // The first valid cycle out of WAIT already carries cell 0.
        cell_en = sol_out_valid;
        if (sol_out_valid) state_nxt = ST_RECV;
        else if (lat_hit)  state_nxt = ST_REPORT;
      end
      ST_RECV: begin
        cell_en  = sol_out_valid;
        cell_idx = recv_idx;
        if (!sol_out_valid || (recv_idx == LAST)) state_nxt = ST_REPORT;
      end
      ST_REPORT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign given    = buffer[cell_idx];
  assign cell_err = (sol_out == 4'd0) || (sol_out > 4'd9)
                  || ((given != 4'd0) && (sol_out != given))
                  || dup;

  sudoku_rcb_tracker u_rcb (
    .clk (clk),
    .rst (rst),
    .clr (start_ok),
    .upd (cell_en),
    .idx (cell_idx),
    .val (sol_out),
    .dup (dup)
  );

  // Puzzle storage carries no reset; ld_ptr alone says what is valid.
  always_ff @(posedge clk) begin
    if ((state == ST_IDLE) && ld_valid && (ld_ptr != FULL)) buffer[ld_ptr] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_ptr    <= 7'd0;
      send_idx  <= 7'd0;
      recv_idx  <= 7'd0;
      err_cnt   <= 7'd0;
      latency   <= 12'd0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      proto_err <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ld_valid && (ld_ptr != FULL)) ld_ptr <= ld_ptr + 7'd1;
          if (sol_out_valid) proto_err <= 1'b1;
          // Clearing on an accepted start takes priority over a stray valid in the same cycle.
          if (start_ok) begin
            send_idx  <= 7'd0;
            recv_idx  <= 7'd0;
            err_cnt   <= 7'd0;
            latency   <= 12'd0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            proto_err <= 1'b0;
          end
        end
        ST_SEND: begin
          send_idx <= send_idx + 7'd1;
          if (sol_out_valid) proto_err <= 1'b1;
        end
        ST_WAIT: begin
          if (!sol_out_valid) begin
            latency <= lat_nxt;
            if (lat_hit) timeout <= 1'b1;
          end
        end
        ST_RECV: begin
          if (!sol_out_valid) proto_err <= 1'b1;
        end
        ST_REPORT: begin
          done   <= 1'b1;
          ld_ptr <= 7'd0;
          pass   <= (err_cnt == 7'd0) && !timeout && !proto_err && !sol_out_valid;
          if (sol_out_valid) proto_err <= 1'b1;
        end
        default: ;
      endcase
      if (cell_en) begin
        recv_idx <= cell_idx + 7'd1;
        if (cell_err && (err_cnt != FULL)) err_cnt <= err_cnt + 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_sudoku_stim_checker.sv
// Purpose: self-checking bench for sudoku_stim_checker with directed vectors, corner sequences and random runs.
// Latency: n/a.
// Backpressure: n/a.
module tb_sudoku_stim_checker;

  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid;
  logic [3:0]  ld_data;
  logic        start;
  logic        busy;
  logic        sol_in_valid;
  logic [3:0]  sol_in;
  logic        sol_out_valid;
  logic [3:0]  sol_out;
  logic        done;
  logic        pass;
  logic [6:0]  err_cnt;
  logic [11:0] latency;
  logic        timeout;
  logic        proto_err;

  int n_chk  = 0;
  int n_fail = 0;

  int perm [9];
  int sol  [81];
  int puz  [81];
  int resp [81];

  typedef struct {
    int d;      // silent WAIT cycles before the solver answers
    int n;      // cells returned; 0 = solver never answers
    int mode;   // 0 correct, 1 given cell 0 -> 6, 2 swap cells 0/1, 3 all zeros
    bit b01;    // cells 0 and 1 blank in the puzzle
    int e_err;
    bit e_pass;
    int e_lat;
    bit e_to;
    bit e_pe;
  } vec_t;

  vec_t tbl [8];

  always #5 clk = ~clk;

  sudoku_stim_checker #(.TIMEOUT_CYC(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .ld_valid      (ld_valid),
    .ld_data       (ld_data),
    .start         (start),
    .busy          (busy),
    .sol_in_valid  (sol_in_valid),
    .sol_in        (sol_in),
    .sol_out_valid (sol_out_valid),
    .sol_out       (sol_out),
    .done          (done),
    .pass          (pass),
    .err_cnt       (err_cnt),
    .latency       (latency),
    .timeout       (timeout),
    .proto_err     (proto_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Cyclic-shift pattern is a valid grid; perm relabels digits.
  task automatic make_sol();
    for (int i = 0; i < 81; i++) begin
      int r, c;
      r = i / 9;
      c = i % 9;
      sol[i] = perm[(r * 3 + r / 3 + c) % 9];
    end
  endtask

  // Reference: a cell is wrong if out of range, contradicts a given, or repeats
  // a digit returned earlier in the same row, column or box.
  function automatic int model_err(input int n);
    int e = 0;
    for (int k = 0; k < n; k++) begin
      int v;
      bit bad;
      v   = resp[k];
      bad = (v == 0) || (v > 9) || ((puz[k] != 0) && (v != puz[k]));
      if (v >= 1 && v <= 9) begin
        for (int j = 0; j < k; j++) begin
          if (resp[j] == v &&
              ((j / 9 == k / 9) || (j % 9 == k % 9) ||
               ((j / 27 == k / 27) && ((j % 9) / 3 == (k % 9) / 3))))
            bad = 1'b1;
        end
      end
      if (bad) e++;
    end
    return (e > 81) ? 81 : e;
  endfunction

  task automatic run(input int d, input int n_send, input int abort_at, input bit extra_ld,
                     input int e_err, input bit e_pass, input int e_lat, input bit e_to,
                     input bit e_pe, input string tag);
    int bad;
    int cyc;
    int dn;
    for (int i = 0; i < 81; i++) begin
      ld_valid = 1'b1;
      ld_data  = 4'(puz[i]);
      @(negedge clk);
    end
    if (extra_ld) begin
      ld_data = 4'(puz[0] + 1);
      @(negedge clk);
    end
    ld_valid = 1'b0;
    ld_data  = 4'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    bad = 0;
    for (int i = 0; i < 81; i++) begin
      if (sol_in_valid !== 1'b1 || sol_in !== 4'(puz[i])) bad++;
      @(negedge clk);
    end
    chk({tag, "_stream"}, bad, 0);
    chk({tag, "_in_idle"}, {sol_in_valid, sol_in}, 0);
    if (n_send > 0) begin
      repeat (d) @(negedge clk);
      for (int k = 0; k < n_send; k++) begin
        sol_out_valid = 1'b1;
        sol_out       = 4'(resp[k]);
        if (k == abort_at) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          sol_out_valid = 1'b0;
          sol_out = 4'd0;
          chk({tag, "_abort_zero"},
              {busy, sol_in_valid, sol_in, done, pass, err_cnt, latency, timeout, proto_err}, 0);
          dn = 0;
          repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
          end
          chk({tag, "_abort_nodone"}, dn, 0);
          return;
        end
        @(negedge clk);
      end
      sol_out_valid = 1'b0;
      sol_out       = 4'd0;
    end
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done_seen"}, done, 1);
    if (done === 1'b1) begin
      chk({tag, "_busy_end"}, busy, 0);
      chk({tag, "_err"}, err_cnt, 32'(e_err));
      chk({tag, "_pass"}, pass, 32'(e_pass));
      chk({tag, "_lat"}, latency, 32'(e_lat));
      chk({tag, "_to"}, timeout, 32'(e_to));
      chk({tag, "_pe"}, proto_err, 32'(e_pe));
      @(negedge clk);
      chk({tag, "_done_once"}, done, 0);
      chk({tag, "_pass_held"}, pass, 32'(e_pass));
    end
  endtask

  task automatic directed_grid(input bit b01);
    for (int k = 0; k < 9; k++) perm[k] = ((k + 4) % 9) + 1;
    make_sol();
    for (int i = 0; i < 81; i++) begin
      puz[i]  = (i % 4 == 3) ? 0 : sol[i];
      resp[i] = sol[i];
    end
    if (b01) begin
      puz[0] = 0;
      puz[1] = 0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e_err, lat, n, sel, d;
    bit to, pe, xl;

    tbl[0] = '{5,  81, 0, 1'b0, 0,  1'b1, 5,  1'b0, 1'b0};
    tbl[1] = '{5,  81, 1, 1'b0, 3,  1'b0, 5,  1'b0, 1'b0};
    tbl[2] = '{5,  81, 2, 1'b1, 2,  1'b0, 5,  1'b0, 1'b0};
    tbl[3] = '{0,  0,  0, 1'b0, 0,  1'b0, TO, 1'b1, 1'b0};
    tbl[4] = '{5,  40, 0, 1'b0, 0,  1'b0, 5,  1'b0, 1'b1};
    tbl[5] = '{0,  81, 0, 1'b0, 0,  1'b1, 0,  1'b0, 1'b0};
    tbl[6] = '{49, 81, 0, 1'b0, 0,  1'b1, 49, 1'b0, 1'b0};
    tbl[7] = '{3,  81, 3, 1'b0, 81, 1'b0, 3,  1'b0, 1'b0};

    rst = 1'b1;
    ld_valid = 1'b0;
    ld_data = 4'd0;
    start = 1'b0;
    sol_out_valid = 1'b0;
    sol_out = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {busy, sol_in_valid, sol_in, done, pass, err_cnt, latency, timeout, proto_err}, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      directed_grid(tbl[v].b01);
      case (tbl[v].mode)
        1: resp[0] = 6;
        2: begin
          resp[0] = sol[1];
          resp[1] = sol[0];
        end
        3: for (int i = 0; i < 81; i++) resp[i] = 0;
        default: ;
      endcase
      run(tbl[v].d, tbl[v].n, -1, 1'b0, tbl[v].e_err, tbl[v].e_pass, tbl[v].e_lat,
          tbl[v].e_to, tbl[v].e_pe, $sformatf("vec%0d", v));
    end

    // Start with only 80 cells loaded must be ignored.
    directed_grid(1'b0);
    for (int i = 0; i < 80; i++) begin
      ld_valid = 1'b1;
      ld_data  = 4'(puz[i]);
      @(negedge clk);
    end
    ld_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("short_load_busy", busy, 0);
    chk("short_load_in_valid", sol_in_valid, 0);
    repeat (3) @(negedge clk);
    chk("short_load_busy_later", busy, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Reset during RECV cell 30, then a clean run.
    directed_grid(1'b0);
    run(4, 81, 30, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, "abort");
    directed_grid(1'b0);
    run(2, 81, -1, 1'b0, 0, 1'b1, 2, 1'b0, 1'b0, "after_abort");

    // Stray solver output while idle flags a protocol error but keeps the verdict.
    sol_out_valid = 1'b1;
    @(negedge clk);
    sol_out_valid = 1'b0;
    chk("idle_stray_pe", proto_err, 1);
    chk("idle_stray_pass_held", pass, 1);

    for (int t = 0; t < 30; t++) begin
      for (int k = 0; k < 9; k++) perm[k] = k + 1;
      for (int k = 8; k > 0; k--) begin
        int j, tmp;
        j = int'($urandom_range(0, k));
        tmp = perm[k];
        perm[k] = perm[j];
        perm[j] = tmp;
      end
      make_sol();
      for (int i = 0; i < 81; i++) begin
        puz[i]  = ($urandom_range(0, 2) == 0) ? 0 : sol[i];
        resp[i] = sol[i];
        if ($urandom_range(0, 9) == 0) resp[i] = int'($urandom_range(0, 15));
      end
      d   = int'($urandom_range(0, 45));
      sel = int'($urandom_range(0, 9));
      n   = (sel == 0) ? 0 : (sel == 1) ? int'($urandom_range(1, 80)) : 81;
      xl  = 1'($urandom_range(0, 1));
      if (n == 0) begin
        e_err = 0;
        lat   = TO;
        to    = 1'b1;
        pe    = 1'b0;
      end else begin
        e_err = model_err(n);
        lat   = d;
        to    = 1'b0;
        pe    = (n < 81);
      end
      run(d, n, -1, xl, e_err, (e_err == 0) && !to && !pe, lat, to, pe, $sformatf("rnd%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
